// File: rtl/eth_mac_stats_pkg.sv
// Shared types and constants for the MAC statistics block.
// Event order matches the status vector bit positions.
package eth_mac_stats_pkg;

  localparam int NUM_EVENTS = 9;

  typedef enum logic [3:0] {
    EV_TX_ERROR_UNDERFLOW = 4'd0,
    EV_TX_FIFO_OVERFLOW   = 4'd1,
    EV_TX_FIFO_BAD_FRAME  = 4'd2,
    EV_TX_FIFO_GOOD_FRAME = 4'd3,
    EV_RX_ERROR_BAD_FRAME = 4'd4,
    EV_RX_ERROR_BAD_FCS   = 4'd5,
    EV_RX_FIFO_OVERFLOW   = 4'd6,
    EV_RX_FIFO_BAD_FRAME  = 4'd7,
    EV_RX_FIFO_GOOD_FRAME = 4'd8
  } eth_mac_event_e;

  localparam logic [3:0] ADDR_PENDING = 4'd9;
  localparam logic [3:0] ADDR_MASK    = 4'd10;

endpackage

// File: rtl/eth_mac_status_interface.sv
// MAC status strobe bundle; each field is a one-cycle pulse.
// The MAC drives it, the statistics block only observes it.
interface eth_mac_status_interface;
  logic tx_error_underflow;
  logic tx_fifo_overflow;
  logic tx_fifo_bad_frame;
  logic tx_fifo_good_frame;
  logic rx_error_bad_frame;
  logic rx_error_bad_fcs;
  logic rx_fifo_overflow;
  logic rx_fifo_bad_frame;
  logic rx_fifo_good_frame;

  modport mac (
    output tx_error_underflow, tx_fifo_overflow,
    output tx_fifo_bad_frame, tx_fifo_good_frame,
    output rx_error_bad_frame, rx_error_bad_fcs,
    output rx_fifo_overflow, rx_fifo_bad_frame,
    output rx_fifo_good_frame
  );

  modport mon (
    input tx_error_underflow, tx_fifo_overflow,
    input tx_fifo_bad_frame, tx_fifo_good_frame,
    input rx_error_bad_frame, rx_error_bad_fcs,
    input rx_fifo_overflow, rx_fifo_bad_frame,
    input rx_fifo_good_frame
  );
endinterface

// File: rtl/eth_mac_stats_counter.sv
// Single saturating event counter.
// A clear coinciding with an event restarts at 1 so no event is lost.
module eth_mac_stat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear wins over hold; increment stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(inc);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/eth_mac_stats.sv
// MAC event counters, read port and sticky maskable interrupt.
// Interrupt logic is built only with ETH_MAC_STATS_IRQ_EN defined.
module eth_mac_stats
  import eth_mac_stats_pkg::*;
#(
  parameter int                    CNT_WIDTH        = 32,
  parameter logic [NUM_EVENTS-1:0] IRQ_DEFAULT_MASK = 9'h1FE
) (
  input  logic                     clk,
  input  logic                     rst,
  eth_mac_status_interface.mon     status,
  input  logic                     rd_req,
  input  logic [3:0]               rd_addr,
  input  logic                     rd_clear,
  output logic                     rd_valid,
  output logic [CNT_WIDTH-1:0]     rd_data,
  input  logic                     mask_we,
  input  logic [NUM_EVENTS-1:0]    mask_wdata,
  output logic                     irq
);

  logic [NUM_EVENTS-1:0] ev;
  logic [NUM_EVENTS-1:0] clr_cnt;
  logic [CNT_WIDTH-1:0]  cnt [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  rd_mux;
  logic                  rd_clr_q;

  assign rd_clr_q = rd_req & rd_clear;

  assign ev[EV_TX_ERROR_UNDERFLOW] = status.tx_error_underflow;
  assign ev[EV_TX_FIFO_OVERFLOW]   = status.tx_fifo_overflow;
  assign ev[EV_TX_FIFO_BAD_FRAME]  = status.tx_fifo_bad_frame;
  assign ev[EV_TX_FIFO_GOOD_FRAME] = status.tx_fifo_good_frame;
  assign ev[EV_RX_ERROR_BAD_FRAME] = status.rx_error_bad_frame;
  assign ev[EV_RX_ERROR_BAD_FCS]   = status.rx_error_bad_fcs;
  assign ev[EV_RX_FIFO_OVERFLOW]   = status.rx_fifo_overflow;
  assign ev[EV_RX_FIFO_BAD_FRAME]  = status.rx_fifo_bad_frame;
  assign ev[EV_RX_FIFO_GOOD_FRAME] = status.rx_fifo_good_frame;

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cnt
    assign clr_cnt[i] = rd_clr_q & (rd_addr == 4'(i));

    eth_mac_stat_counter #(
      .W (CNT_WIDTH)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (ev[i]),
      .clr (clr_cnt[i]),
      .cnt (cnt[i])
    );
  end

`ifdef ETH_MAC_STATS_IRQ_EN
  logic [NUM_EVENTS-1:0] pending;
  logic [NUM_EVENTS-1:0] mask;
  logic                  clr_pend;

  assign clr_pend = rd_clr_q & (rd_addr == ADDR_PENDING);

  // Sticky pending, mask register and registered irq level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= IRQ_DEFAULT_MASK;
      irq     <= 1'b0;
    end else begin
      pending <= (clr_pend ? '0 : pending) | ev;
      if (mask_we) mask <= mask_wdata;
      irq <= |(pending & mask);
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^{mask_we, mask_wdata};
  assign irq = 1'b0;
`endif

  // Select pre-update register value for the requested address.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (rd_addr < 4'(NUM_EVENTS)): rd_mux = cnt[rd_addr];
`ifdef ETH_MAC_STATS_IRQ_EN
      (rd_addr == ADDR_PENDING):  rd_mux = CNT_WIDTH'(pending);
      (rd_addr == ADDR_MASK):     rd_mux = CNT_WIDTH'(mask);
`endif
      default:                    rd_mux = '0;
    endcase
  end

  // One-cycle read response; data holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_eth_mac_stats.sv
// Randomized self-checking bench for eth_mac_stats (32- and 8-bit builds).
// Expected values come from an event-count model of the block.
module tb_eth_mac_stats;

`ifdef ETH_MAC_STATS_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd_clear = 1'b0;
  logic        mask_we = 1'b0;
  logic [8:0]  mask_wdata = '0;
  logic        rd_valid, rd_valid8;
  logic [31:0] rd_data;
  logic [7:0]  rd_data8;
  logic        irq, irq8;

  eth_mac_status_interface st ();

  eth_mac_stats #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .status(st),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_clear(rd_clear),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq(irq)
  );

  eth_mac_stats #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .status(st),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_clear(rd_clear),
    .rd_valid(rd_valid8), .rd_data(rd_data8),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq(irq8)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          tot [9];
  logic [8:0]  pend, mask;
  logic        e_valid, e_irq;
  logic [31:0] e_data;
  logic [7:0]  e_data8;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) tot[i] = 0;
    pend = '0;
    mask = 9'h1FE;
    e_valid = 1'b0;
    e_irq = 1'b0;
    e_data = '0;
    e_data8 = '0;
  endtask

  task automatic drive_ev(input logic [8:0] ev);
    {st.rx_fifo_good_frame, st.rx_fifo_bad_frame, st.rx_fifo_overflow,
     st.rx_error_bad_fcs, st.rx_error_bad_frame, st.tx_fifo_good_frame,
     st.tx_fifo_bad_frame, st.tx_fifo_overflow, st.tx_error_underflow} = ev;
  endtask

  task automatic cycle(input logic [8:0] ev, input logic req,
                       input logic [3:0] a, input logic clr,
                       input logic mwe, input logic [8:0] mwd);
    logic [31:0] v;
    drive_ev(ev);
    rd_req = req; rd_addr = a; rd_clear = clr;
    mask_we = mwe; mask_wdata = mwd;
    v = '0;
    if (a < 9) v = 32'(tot[a]);
    else if (IRQ && a == 9) v = 32'(pend);
    else if (IRQ && a == 10) v = 32'(mask);
    if (req) begin
      e_data = v;
      e_data8 = (a < 9 && tot[a] > 255) ? 8'hFF : v[7:0];
    end
    e_valid = req;
    e_irq = IRQ && (|(pend & mask));
    for (int i = 0; i < 9; i++) begin
      if (req && clr && a == 4'(i)) tot[i] = int'(ev[i]);
      else tot[i] += int'(ev[i]);
    end
    if (IRQ) begin
      if (req && clr && a == 9) pend = '0;
      pend |= ev;
      if (mwe) mask = mwd;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_ev('0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({rd_valid, rd_data, irq, rd_valid8, rd_data8, irq8} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%h irq=%0b v8=%0b d8=%h exp all 0",
               rd_valid, rd_data, irq, rd_valid8, rd_data8);
    end
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      cycle('0, 1'b1, 4'(a), 1'b0, 1'b0, '0);
      n_chk++;
      if ({rd_valid, rd_data, rd_valid8, rd_data8} !==
          {1'b1, (IRQ && a == 10) ? 32'h1FE : 32'h0,
           1'b1, (IRQ && a == 10) ? 8'hFE : 8'h0}) begin
        n_fail++;
        $display("FAIL reset_read a=%0d: got v=%0b d=%h d8=%h", a, rd_valid, rd_data, rd_data8);
      end
    end
  endtask

  task automatic test_count_clear();
    for (int i = 0; i < 5; i++) begin
      cycle(9'h100, 1'b0, '0, 1'b0, 1'b0, '0);
      cycle('0, 1'b0, '0, 1'b0, 1'b0, '0);
    end
    cycle('0, 1'b1, 4'd8, 1'b1, 1'b0, '0);
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd5 || rd_data8 !== 8'd5) begin
      n_fail++;
      $display("FAIL count_clear: got v=%0b d=%0d d8=%0d exp 1 5 5", rd_valid, rd_data, rd_data8);
    end
    cycle('0, 1'b1, 4'd8, 1'b0, 1'b0, '0);
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0 || rd_data8 !== 8'd0) begin
      n_fail++;
      $display("FAIL count_after_clear: got d=%0d d8=%0d exp 0", rd_data, rd_data8);
    end
    cycle('0, 1'b0, 4'd8, 1'b0, 1'b0, '0);
    n_chk++;
    if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL read_hold: got v=%0b d=%0d exp 0 0", rd_valid, rd_data);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) cycle(9'h020, 1'b0, '0, 1'b0, 1'b0, '0);
    cycle('0, 1'b1, 4'd5, 1'b0, 1'b0, '0);
    n_chk++;
    if (rd_data8 !== 8'd255 || rd_data !== e_data || e_data !== 32'd300) begin
      n_fail++;
      $display("FAIL saturate: got d=%0d d8=%0d exp 300 255", rd_data, rd_data8);
    end
  endtask

  task automatic test_clear_collision();
    cycle('0, 1'b1, 4'd6, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) cycle(9'h040, 1'b0, '0, 1'b0, 1'b0, '0);
    cycle(9'h040, 1'b1, 4'd6, 1'b1, 1'b0, '0);
    n_chk++;
    if (rd_data !== 32'd7 || rd_data8 !== 8'd7) begin
      n_fail++;
      $display("FAIL collision_old: got d=%0d d8=%0d exp 7", rd_data, rd_data8);
    end
    cycle('0, 1'b1, 4'd6, 1'b0, 1'b0, '0);
    n_chk++;
    if (rd_data !== 32'd1 || rd_data8 !== 8'd1) begin
      n_fail++;
      $display("FAIL collision_new: got d=%0d d8=%0d exp 1", rd_data, rd_data8);
    end
  endtask

  task automatic test_irq();
    logic [8:0] sev [17];
    logic [3:0] sad [17];
    logic [16:0] sreq, sclr, smwe;
    logic [8:0] smwd [17];
    for (int i = 0; i < 17; i++) begin
      sev[i] = '0; sad[i] = '0; smwd[i] = '0;
    end
    sreq = '0; sclr = '0; smwe = '0;
    sreq[0] = 1; sad[0] = 10; smwe[0] = 1; smwd[0] = 9'h001;
    sreq[1] = 1; sad[1] = 9; sclr[1] = 1;
    sev[3] = 9'h008;
    sev[7] = 9'h001;
    sreq[10] = 1; sad[10] = 9;
    sreq[11] = 1; sad[11] = 9; sclr[11] = 1;
    sreq[14] = 1; sad[14] = 9;
    sev[15] = 9'h001;
    smwe[16] = 1; smwd[16] = 9'h000;
    for (int s = 0; s < 17; s++) begin
      cycle(sev[s], sreq[s], sad[s], sclr[s], smwe[s], smwd[s]);
      n_chk++;
      if ({rd_valid, rd_data, rd_data8, irq, irq8} !==
          {e_valid, e_data, e_data8, e_irq, e_irq}) begin
        n_fail++;
        $display("FAIL irq_step%0d: got v=%0b d=%h d8=%h irq=%0b/%0b exp v=%0b d=%h d8=%h irq=%0b",
                 s, rd_valid, rd_data, rd_data8, irq, irq8, e_valid, e_data, e_data8, e_irq);
      end
    end
    repeat (2) cycle('0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_mask_off: got %0b exp 0", irq);
    end
    cycle('0, 1'b0, '0, 1'b0, 1'b1, 9'h1FF);
    cycle('0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (irq !== IRQ) begin
      n_fail++;
      $display("FAIL irq_mask_on: got %0b exp %0b", irq, IRQ);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      cycle(9'($urandom & $urandom), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, 9'($urandom));
      n_chk++;
      if ({rd_valid, rd_data, rd_data8, irq, irq8} !==
          {e_valid, e_data, e_data8, e_irq, e_irq}) begin
        n_fail++;
        $display("FAIL random_%0d: got v=%0b d=%h d8=%h irq=%0b/%0b exp v=%0b d=%h d8=%h irq=%0b",
                 n, rd_valid, rd_data, rd_data8, irq, irq8, e_valid, e_data, e_data8, e_irq);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    cycle(9'h1FF, 1'b0, '0, 1'b0, 1'b0, '0);
    cycle('0, 1'b1, 4'd0, 1'b0, 1'b0, '0);
    n_chk++;
    if (rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %0b exp 1", rd_valid);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({rd_valid, rd_valid8, rd_data, irq} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%0b v8=%0b d=%h irq=%0b exp 0", rd_valid, rd_valid8, rd_data, irq);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle('0, 1'b1, 4'd0, 1'b0, 1'b0, '0);
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_read: got v=%0b d=%0d exp 1 0", rd_valid, rd_data);
    end
  endtask

  initial begin
    drive_ev('0);
    model_reset();
    test_reset();
    test_count_clear();
    test_saturate();
    test_clear_collision();
    test_irq();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_mac_stats.md
# eth_mac_stats

Event statistics and interrupt controller for the Ethernet MAC status bundle. It samples the nine single-cycle status strobes every clock, keeps one saturating counter per event, serves a one-cycle-latency read port with optional clear-on-read, and raises a maskable, sticky interrupt. It sits beside the MAC in the `clk` domain, between the MAC status outputs and the management/CSR logic.

## Interface
Parameters:
- `CNT_WIDTH`, 32, counter width in bits, minimum 8.
- `IRQ_DEFAULT_MASK`, 9'h1FE, reset value of the internal interrupt mask (bit i = 1 enables event i).

Ports:
- `clk`  input  1  single clock; all logic is synchronous to its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `status`  input  eth_mac_status_interface  MAC status strobes, read only; each field is a one-cycle pulse.
- `rd_req`  input  1  read strobe.
- `rd_addr`  input  4  register index.
- `rd_clear`  input  1  clear the addressed counter or pending bits; qualified by `rd_req`.
- `rd_valid`  output  1  read data valid.
- `rd_data`  output  CNT_WIDTH  read data.
- `mask_we`  input  1  load `mask_wdata` into the interrupt mask.
- `mask_wdata`  input  9  new interrupt mask.
- `irq`  output  1  level interrupt.

## Operation
- Event index: 0 tx_error_underflow, 1 tx_fifo_overflow, 2 tx_fifo_bad_frame, 3 tx_fifo_good_frame, 4 rx_error_bad_frame, 5 rx_error_bad_fcs, 6 rx_fifo_overflow, 7 rx_fifo_bad_frame, 8 rx_fifo_good_frame.
- Counters: +1 per cycle in which the strobe is high. They saturate at all-ones and never wrap.
- Address map:
  - 0–8: counters.
  - 9: pending bits, zero-extended.
  - 10: mask, zero-extended.
  - 11–15: read as 0, and a clear has no effect.
- Read: `rd_req` is accepted every cycle, with no backpressure. Data is captured from the pre-update counter value in the request cycle.
- Clear on a counter: the counter is set to 0. If its event strobes in the same cycle, it is set to 1 instead; no event is lost, and the read returns the old value.
- Clear on address 9: all pending bits are acknowledged. A pending bit whose event strobes in the same cycle stays set.
- Pending bit i sets on event i regardless of mask. It is cleared only by a clear on address 9.
- `irq` = OR(pending & mask), registered.
- `mask_we` takes effect the next cycle. Combined with a read of address 10 in the same cycle, the read returns the old mask.

## Timing
- Reset values:
  - All outputs: `rd_valid`=0, `rd_data`=0, `irq`=0.
  - Internal state: counters = 0, pending = 0, mask = `IRQ_DEFAULT_MASK`.
- Read latency: `rd_valid` and `rd_data` are registered, valid exactly one cycle after `rd_req`, and high for one cycle per request. `rd_data` holds its last value while `rd_valid`=0.
- Back-to-back `rd_req` gives back-to-back `rd_valid`.
- Counter update is visible to a read issued the cycle after the strobe.
- `irq` latency: asserts 2 cycles after an enabled strobe (pending register, then irq register). It deasserts 2 cycles after an acknowledge or a mask clear.
- Reset asserted mid-read: `rd_valid` drops immediately (asynchronously), and the read is discarded.

## Configuration
- `ETH_MAC_STATS_IRQ_EN` defined: pending register, mask, and `irq` logic are present as described above.
- `ETH_MAC_STATS_IRQ_EN` undefined:
  - Pending and mask logic are removed, and `irq` is tied to 0.
  - `mask_we` is ignored.
  - Addresses 9 and 10 read as 0.
  - Counters and the read port are unchanged.

## Structure
- Shared package `eth_mac_stats_pkg`:
  - `NUM_EVENTS`=9.
  - Event index enum `eth_mac_event_e`.
  - Address constants `ADDR_PENDING`=9 and `ADDR_MASK`=10.
- Sub-module `eth_mac_stat_counter`: one saturating counter with `inc` and `clr` inputs implementing the simultaneous-clear rule. Instantiated 9 times via generate.
- Top level holds event packing, read mux, pending/mask, and irq registers.

## Test plan
- Reset, then read all 16 addresses → `rd_valid` one cycle after each request. Data 0 everywhere except address 10 = 0x1FE (IRQ build).
- 5 pulses on rx_fifo_good_frame, then read addr 8 with clear → returns 5; a second read returns 0.
- `CNT_WIDTH`=8: 300 pulses on rx_error_bad_fcs → addr 5 reads 255.
- rx_fifo_overflow strobe in the same cycle as clear of addr 6 (count 7) → read returns 7; the next read returns 1.
- Mask = 9'h001, pulse tx_error_underflow → `irq`=1 two cycles later.
  - Pulse tx_fifo_good_frame alone → `irq` unaffected.
  - Clear addr 9 → `irq`=0 two cycles later.
  - Pending for bit 3 is still set until that clear.
- Build without `ETH_MAC_STATS_IRQ_EN`: enabled events → `irq` stays 0, and addr 9 and 10 read 0.
